// File: rtl/sevenseg_pkg.sv
// Shared constants and types for the multiplexed seven-segment driver:
// active-low hex font, segment-off pattern and the per-slot phase encoding.
package sevenseg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Entry n is the {g,f,e,d,c,b,a} active-low pattern for hex digit n.
    localparam logic [15:0][6:0] FONT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic [1:0] {
        BLANK,
        ON,
        OFF
    } phase_e;

endpackage

// File: rtl/sevenseg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module sevenseg_hex_decode
    import sevenseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = FONT[nibble];
    end

endmodule

// File: rtl/sevenseg_scan.sv
// Multiplexed common-anode seven-segment scanner with anti-ghost blanking,
// PWM brightness and a double-buffered display image swapped at frame end.
module sevenseg_scan
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_HZ       = 50_000_000,
    parameter int REFRESH_HZ   = 1000,
    parameter int GHOST_CYCLES = 16,
    parameter int BW           = 4
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     blank_in,
    input  logic [BW-1:0]             brightness,
    output logic                      pending,
    output logic                      frame_start,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     an
);

    localparam int SLOT = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
    localparam int A    = SLOT - GHOST_CYCLES;
    localparam int SW   = $clog2(SLOT);
    localparam int DW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW   = $clog2(A) + BW;
    localparam int OW   = $clog2(A + 1);

    logic [SW-1:0]           slot_cnt_q, slot_cnt_d;
    logic [DW-1:0]           digit_idx_q, digit_idx_d;
    logic [4*NUM_DIGITS-1:0] pend_digits_q, act_digits_q;
    logic [NUM_DIGITS-1:0]   pend_dp_q, act_dp_q;
    logic [NUM_DIGITS-1:0]   pend_blank_q, act_blank_q;
    logic                    pending_q;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    frame_start_q, frame_start_d;

    logic                    slot_wrap, last_digit, boundary;
    logic [PW-1:0]           on_prod;
    logic [OW-1:0]           on_cycles;
    logic [SW:0]             on_end;
    phase_e                  phase;
    logic [3:0]              cur_nib;
    logic                    cur_dp, cur_blank;
    logic [6:0]              cur_seg;

    always_comb begin
        slot_wrap   = (slot_cnt_q == SW'(SLOT - 1));
        last_digit  = (digit_idx_q == DW'(NUM_DIGITS - 1));
        boundary    = slot_wrap && last_digit;
        slot_cnt_d  = slot_wrap ? '0 : slot_cnt_q + 1'b1;
        digit_idx_d = digit_idx_q;
        if (slot_wrap) begin
            digit_idx_d = last_digit ? '0 : digit_idx_q + 1'b1;
        end
    end

    // Full-scale brightness maps to the whole ON window rather than A*(2^BW-1)/2^BW.
    always_comb begin
        on_prod   = PW'(A) * PW'(brightness);
        on_cycles = (brightness == '1) ? OW'(A) : OW'(on_prod >> BW);
        on_end    = (SW + 1)'(GHOST_CYCLES) + (SW + 1)'(on_cycles);
        if (slot_cnt_q < SW'(GHOST_CYCLES)) begin
            phase = BLANK;
        end else if ({1'b0, slot_cnt_q} < on_end) begin
            phase = ON;
        end else begin
            phase = OFF;
        end
    end

    always_comb begin
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx_q == DW'(i)) begin
                cur_nib   = act_digits_q[4*i +: 4];
                cur_dp    = act_dp_q[i];
                cur_blank = act_blank_q[i];
            end
        end
    end

    sevenseg_hex_decode u_dec (
        .nibble (cur_nib),
        .seg    (cur_seg)
    );

    always_comb begin
        an_d          = '1;
        seg_d         = SEG_OFF;
        dp_d          = 1'b1;
        frame_start_d = (digit_idx_q == '0) && (slot_cnt_q == '0);
        if (phase == ON && !cur_blank) begin
            seg_d = cur_seg;
            dp_d  = ~cur_dp;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (digit_idx_q == DW'(i)) begin
                    an_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slot_cnt_q    <= '0;
            digit_idx_q   <= '0;
            an_q          <= '1;
            seg_q         <= SEG_OFF;
            dp_q          <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            slot_cnt_q    <= slot_cnt_d;
            digit_idx_q   <= digit_idx_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            frame_start_q <= frame_start_d;
        end
    end

    // A load landing on the boundary goes straight to the active image.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_digits_q <= '0;
            pend_dp_q     <= '0;
            pend_blank_q  <= '1;
            act_digits_q  <= '0;
            act_dp_q      <= '0;
            act_blank_q   <= '1;
            pending_q     <= 1'b0;
        end else if (boundary) begin
            pending_q <= 1'b0;
            if (load) begin
                act_digits_q <= digits_in;
                act_dp_q     <= dp_in;
                act_blank_q  <= blank_in;
            end else if (pending_q) begin
                act_digits_q <= pend_digits_q;
                act_dp_q     <= pend_dp_q;
                act_blank_q  <= pend_blank_q;
            end
        end else if (load) begin
            pend_digits_q <= digits_in;
            pend_dp_q     <= dp_in;
            pend_blank_q  <= blank_in;
            pending_q     <= 1'b1;
        end
    end

    assign pending     = pending_q;
    assign frame_start = frame_start_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    assign an          = an_q;

endmodule
